// File: rtl/pcie_pipe_rate_pkg.sv
// rtl/pcie_pipe_rate_pkg.sv - shared types and sizing helpers for the PIPE rate sequencer
package pcie_pipe_rate_pkg;

  typedef enum logic [1:0] {
    RATE_GEN1 = 2'd0,
    RATE_GEN2 = 2'd1,
    RATE_GEN3 = 2'd2,
    RATE_RSVD = 2'd3
  } rate_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    SWITCH   = 3'd2,
    LOCKWAIT = 3'd3,
    LANEWAIT = 3'd4,
    ERRREV   = 3'd5,
    DONE     = 3'd6
  } seq_state_t;

  localparam int TIMEOUT_CYCLES_DFLT = 1024;

  // Width able to hold 0..n, so one counter serves settle, lock and timeout budgets.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pcie_pipe_lane_done_tracker.sv
// rtl/pcie_pipe_lane_done_tracker.sv - per-lane sticky rate-done capture with masked all_done
module pcie_pipe_lane_done_tracker #(
  parameter int PCIE_LANE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PCIE_LANE-1:0] done,
  input  logic [PCIE_LANE-1:0] mask,
  output logic                 all_done
);

  logic [PCIE_LANE-1:0] sticky;

  // A pulse arriving in the clearing cycle is kept: capture starts at the switch itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
    end else begin
      sticky <= (clr ? '0 : sticky) | (en ? done : '0);
    end
  end

  assign all_done = ((sticky & mask) == mask);

endmodule

// File: rtl/pcie_k7_pipe_rate_sequencer.sv
// rtl/pcie_k7_pipe_rate_sequencer.sv - PIPE Gen1/2/3 rate-change sequencer with timeout revert
// Optional statistics counters: define PCIE_RATE_STATS_EN.
module pcie_k7_pipe_rate_sequencer
  import pcie_pipe_rate_pkg::*;
#(
  parameter int PCIE_LANE       = 8,
  parameter int PCIE_LINK_SPEED = 3,
  parameter int SETTLE_CYCLES   = 4,
  parameter int LOCK_STABLE     = 8,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DFLT
) (
  input  logic                 CLK_CLK,
  input  logic                 CLK_RST_N,
  input  logic                 RATE_REQ_VALID,
  input  logic [1:0]           RATE_REQ,
  output logic                 RATE_REQ_READY,
  input  logic [PCIE_LANE-1:0] LANE_ACTIVE,
  input  logic [PCIE_LANE-1:0] LANE_RATE_DONE,
  input  logic                 MMCM_LOCK,
  output logic [PCIE_LANE-1:0] CLK_PCLK_SEL,
  output logic                 CLK_GEN3,
  output logic [1:0]           RATE_CUR,
  output logic                 RATE_ACK,
  output logic                 RATE_ERR
`ifdef PCIE_RATE_STATS_EN
  ,
  output logic [15:0]          STAT_CHANGES,
  output logic [15:0]          STAT_TIMEOUTS
`endif
);

  localparam int MAXC = (TIMEOUT_CYCLES > LOCK_STABLE)
                        ? ((TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES)
                        : ((LOCK_STABLE > SETTLE_CYCLES) ? LOCK_STABLE : SETTLE_CYCLES);
  localparam int CW = cnt_width(MAXC);
  localparam logic [1:0] MAX_RATE = 2'(PCIE_LINK_SPEED - 1);

  seq_state_t           state;
  rate_t                target;
  rate_t                rate_cur;
  logic [PCIE_LANE-1:0] mask;
  logic [PCIE_LANE-1:0] sel;
  logic [PCIE_LANE-1:0] prev_sel;
  logic                 gen3;
  logic                 prev_gen3;
  logic                 rate_err;
  logic [CW-1:0]        phase_cnt;
  logic [CW-1:0]        tmo_cnt;
  logic                 all_done;
  logic                 accept;
  logic                 reject;
  logic                 tmo_hit;

  assign RATE_REQ_READY = (state == IDLE) && MMCM_LOCK;
  assign accept         = RATE_REQ_READY && RATE_REQ_VALID;
  assign reject         = (RATE_REQ == 2'd3) || (RATE_REQ > MAX_RATE);
  assign tmo_hit        = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  pcie_pipe_lane_done_tracker #(
    .PCIE_LANE (PCIE_LANE)
  ) u_done_tracker (
    .clk      (CLK_CLK),
    .rst_n    (CLK_RST_N),
    .clr      (state == SWITCH),
    .en       ((state == SWITCH) || (state == LOCKWAIT) || (state == LANEWAIT)),
    .done     (LANE_RATE_DONE),
    .mask     (mask),
    .all_done (all_done)
  );

  always_ff @(posedge CLK_CLK or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      state     <= IDLE;
      target    <= RATE_GEN1;
      rate_cur  <= RATE_GEN1;
      mask      <= '0;
      sel       <= '0;
      prev_sel  <= '0;
      gen3      <= 1'b0;
      prev_gen3 <= 1'b0;
      rate_err  <= 1'b0;
      phase_cnt <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target    <= rate_t'(RATE_REQ);
            mask      <= LANE_ACTIVE;
            rate_err  <= reject;
            phase_cnt <= '0;
            if (reject || (RATE_REQ == rate_cur)) state <= DONE;
            else                                  state <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase_cnt == CW'(SETTLE_CYCLES - 1)) begin
            phase_cnt <= '0;
            state     <= SWITCH;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SWITCH: begin
          prev_sel  <= sel;
          prev_gen3 <= gen3;
          sel       <= mask & {PCIE_LANE{target != RATE_GEN1}};
          gen3      <= (target == RATE_GEN3);
          tmo_cnt   <= '0;
          phase_cnt <= '0;
          state     <= LOCKWAIT;
        end
        LOCKWAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // Timeout wins over a lock that completes in the very last budget cycle.
          if (tmo_hit) begin
            state <= ERRREV;
          end else if (!MMCM_LOCK) begin
            phase_cnt <= '0;
          end else if (phase_cnt == CW'(LOCK_STABLE - 1)) begin
            state <= LANEWAIT;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        LANEWAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            state <= ERRREV;
          end else if (all_done) begin
            rate_cur <= target;
            state    <= DONE;
          end
        end
        ERRREV: begin
          sel      <= prev_sel;
          gen3     <= prev_gen3;
          rate_err <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign CLK_PCLK_SEL = sel;
  assign CLK_GEN3     = gen3;
  assign RATE_CUR     = rate_cur;
  assign RATE_ACK     = (state == DONE);
  assign RATE_ERR     = rate_err;

`ifdef PCIE_RATE_STATS_EN
  always_ff @(posedge CLK_CLK or negedge CLK_RST_N) begin
    if (!CLK_RST_N) begin
      STAT_CHANGES  <= '0;
      STAT_TIMEOUTS <= '0;
    end else begin
      if ((state == LANEWAIT) && !tmo_hit && all_done && (STAT_CHANGES != 16'hFFFF))
        STAT_CHANGES <= STAT_CHANGES + 16'd1;
      if ((state == ERRREV) && (STAT_TIMEOUTS != 16'hFFFF))
        STAT_TIMEOUTS <= STAT_TIMEOUTS + 16'd1;
    end
  end
`endif

endmodule
